// File: rtl/gray_stream_tx_pkg.sv
// Shared image-stream defaults (resolution and blanking) plus counter-sizing helpers.
package gray_stream_tx_pkg;

    localparam int unsigned DefDataWidth = 8;
    localparam int unsigned DefImgWidth  = 640;
    localparam int unsigned DefImgHeight = 480;
    localparam int unsigned DefHBlank    = 16;
    localparam int unsigned DefVBlank    = 32;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

    // Bits needed to count 0..max_val-1; never zero width.
    function automatic int unsigned cnt_width(input int unsigned max_val);
        return (max_val > 1) ? $clog2(max_val) : 1;
    endfunction

endpackage

// File: rtl/gray_stream_tx.sv
// Raster gray-pixel transmitter: pulls pixels from an upstream source and emits them
// framed by hsync/vsync with programmable horizontal and vertical blanking.
module gray_stream_tx
    import gray_stream_tx_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DefDataWidth,
    parameter int unsigned IMG_WIDTH  = DefImgWidth,
    parameter int unsigned IMG_HEIGHT = DefImgHeight,
    parameter int unsigned H_BLANK    = DefHBlank,
    parameter int unsigned V_BLANK    = DefVBlank
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  enable,
    input  logic                  src_valid,
    input  logic [DATA_WIDTH-1:0] src_data,
    output logic                  src_ready,
    output logic                  gray_valid,
    output logic                  gray_hsync,
    output logic                  gray_vsync,
    output logic [DATA_WIDTH-1:0] gray,
    output logic                  frame_done
);

    localparam int unsigned ColW = cnt_width(IMG_WIDTH);
    localparam int unsigned RowW = cnt_width(IMG_HEIGHT);
    localparam int unsigned BlkW = cnt_width(max_u(H_BLANK, V_BLANK));

    localparam logic [ColW-1:0] ColLast = ColW'(IMG_WIDTH - 1);
    localparam logic [RowW-1:0] RowLast = RowW'(IMG_HEIGHT - 1);
    localparam logic [BlkW-1:0] HbLast  = BlkW'(H_BLANK - 1);
    localparam logic [BlkW-1:0] VbLast  = BlkW'(V_BLANK - 1);

    typedef enum logic [1:0] {StIdle, StVblank, StActive, StHblank} state_e;

    state_e          state_q, state_d;
    logic [ColW-1:0] col_q, col_d;
    logic [RowW-1:0] row_q, row_d;
    logic [BlkW-1:0] blank_q, blank_d;

    logic handshake;
    logic last_col;
    logic last_row;

    assign src_ready = (state_q == StActive);
    assign handshake = src_valid && src_ready;
    assign last_col  = (col_q == ColLast);
    assign last_row  = (row_q == RowLast);

    always_comb begin
        state_d = state_q;
        col_d   = col_q;
        row_d   = row_q;
        blank_d = blank_q;
        unique case (state_q)
            StIdle: begin
                if (enable) begin
                    state_d = StVblank;
                    blank_d = '0;
                end
            end
            StVblank: begin
                if (blank_q == VbLast) begin
                    state_d = StActive;
                    blank_d = '0;
                    row_d   = '0;
                    col_d   = '0;
                end else begin
                    blank_d = blank_q + 1'b1;
                end
            end
            StActive: begin
                if (handshake) begin
                    if (last_col) begin
                        col_d   = '0;
                        blank_d = '0;
                        if (!last_row) begin
                            state_d = StHblank;
                        end else begin
                            // enable only matters here and in idle; a drop mid-frame waits
                            state_d = enable ? StVblank : StIdle;
                        end
                    end else begin
                        col_d = col_q + 1'b1;
                    end
                end
            end
            StHblank: begin
                if (blank_q == HbLast) begin
                    state_d = StActive;
                    blank_d = '0;
                    row_d   = row_q + 1'b1;
                end else begin
                    blank_d = blank_q + 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            col_q      <= '0;
            row_q      <= '0;
            blank_q    <= '0;
            gray_valid <= 1'b0;
            gray_hsync <= 1'b0;
            gray_vsync <= 1'b0;
            gray       <= '0;
            frame_done <= 1'b0;
        end else begin
            state_q    <= state_d;
            col_q      <= col_d;
            row_q      <= row_d;
            blank_q    <= blank_d;
            gray_valid <= handshake;
            gray       <= handshake ? src_data : '0;
            gray_hsync <= (state_q == StActive);
            gray_vsync <= (state_q == StActive) || (state_q == StHblank);
            // Coincides with the last pixel, i.e. the final cycle vsync is high.
            frame_done <= handshake && last_col && last_row;
        end
    end

endmodule

// File: tb/tb_gray_stream_tx.sv
// Scoreboard bench for gray_stream_tx on a 4x3 image with 2/3-cycle blanking.
module tb_gray_stream_tx;

    localparam int DW = 8;
    localparam int W  = 4;
    localparam int H  = 3;
    localparam int HB = 2;
    localparam int VB = 3;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          enable;
    logic          src_valid;
    logic [DW-1:0] src_data;
    logic          src_ready;
    logic          gray_valid;
    logic          gray_hsync;
    logic          gray_vsync;
    logic [DW-1:0] gray;
    logic          frame_done;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    gray_stream_tx #(
        .DATA_WIDTH(DW),
        .IMG_WIDTH (W),
        .IMG_HEIGHT(H),
        .H_BLANK   (HB),
        .V_BLANK   (VB)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .enable    (enable),
        .src_valid (src_valid),
        .src_data  (src_data),
        .src_ready (src_ready),
        .gray_valid(gray_valid),
        .gray_hsync(gray_hsync),
        .gray_vsync(gray_vsync),
        .gray      (gray),
        .frame_done(frame_done)
    );

    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] got_q[$];
    int            hs_idx[$];
    int            out_idx[$];
    int            hs_run[$];
    int            gap_run[$];

    logic [DW-1:0] next_pix;
    int            n_push;
    int            cyc = 0;

    logic          s_valid, s_hs, s_vs, s_fd, s_ready;
    logic [DW-1:0] s_gray;

    int lead, pulses, vs_cnt, fd_cnt, fd_aligned, bad_gray, fd_idx, first_hs_idx;
    bit timed_out;

    task automatic do_reset(input logic en);
        rst_n     = 1'b0;
        enable    = en;
        src_valid = 1'b0;
        src_data  = '0;
        exp_q.delete();
        next_pix  = 8'h10;
        n_push    = 0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // One clock: sample outputs at the falling edge, then drive the source for the next
    // rising edge and log a scoreboard entry if that edge will complete a handshake.
    task automatic tick(input logic v);
        @(negedge clk);
        cyc++;
        s_valid   = gray_valid;
        s_hs      = gray_hsync;
        s_vs      = gray_vsync;
        s_fd      = frame_done;
        s_gray    = gray;
        s_ready   = src_ready;
        src_valid = v;
        src_data  = next_pix;
        if (v && s_ready) begin
            exp_q.push_back(next_pix);
            hs_idx.push_back(cyc);
            next_pix++;
            n_push++;
        end
    endtask

    // Collects one frame of output activity; ends on the first vsync-low after hsync.
    task automatic run_frame(input int stall_at, input bit drop_en);
        int  cur_hs;
        int  cur_gap;
        int  base;
        int  stall_left;
        bit  seen;
        logic v;
        got_q.delete(); out_idx.delete(); hs_idx.delete(); hs_run.delete(); gap_run.delete();
        lead = 0; pulses = 0; vs_cnt = 0; fd_cnt = 0; fd_aligned = 0; bad_gray = 0;
        fd_idx = -1; first_hs_idx = -1; timed_out = 1'b1;
        cur_hs = 0; cur_gap = 0; seen = 1'b0; stall_left = 2; base = n_push;
        for (int c = 0; c < 300; c++) begin
            v = 1'b1;
            if (stall_at >= 0 && (n_push - base) == stall_at && stall_left > 0) begin
                v = 1'b0;
                stall_left--;
            end
            tick(v);
            if (drop_en && s_hs) enable = 1'b0;
            if (!seen && !s_hs) lead++;
            if (!seen && s_hs) begin
                seen = 1'b1;
                first_hs_idx = cyc;
            end
            if (s_valid) begin
                pulses++;
                got_q.push_back(s_gray);
                out_idx.push_back(cyc);
            end else if (s_gray !== '0) begin
                bad_gray++;
            end
            if (s_vs) vs_cnt++;
            if (s_fd) begin
                fd_cnt++;
                fd_idx = cyc;
                if (s_valid && s_vs && s_hs) fd_aligned++;
            end
            if (s_hs) cur_hs++;
            else if (cur_hs > 0) begin
                hs_run.push_back(cur_hs);
                cur_hs = 0;
            end
            if (s_vs && !s_hs) cur_gap++;
            else if (cur_gap > 0) begin
                gap_run.push_back(cur_gap);
                cur_gap = 0;
            end
            if (seen && !s_vs) begin
                timed_out = 1'b0;
                break;
            end
        end
    endtask

    task automatic test_reset();
        int held_bad;
        do_reset(1'b1);
        for (int i = 0; i < 8; i++) tick(1'b1);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        total++; if (gray_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b, expected 0", gray_valid); end
        total++; if (gray !== '0) begin bad++; $display("FAIL reset_gray: got %h, expected 00", gray); end
        total++; if (gray_hsync !== 1'b0) begin bad++; $display("FAIL reset_hsync: got %b, expected 0", gray_hsync); end
        total++; if (gray_vsync !== 1'b0) begin bad++; $display("FAIL reset_vsync: got %b, expected 0", gray_vsync); end
        total++; if (frame_done !== 1'b0) begin bad++; $display("FAIL reset_fdone: got %b, expected 0", frame_done); end
        total++; if (src_ready !== 1'b0) begin bad++; $display("FAIL reset_ready: got %b, expected 0", src_ready); end
        held_bad = 0;
        for (int i = 0; i < 3; i++) begin
            tick(1'b1);
            if (s_ready !== 1'b0 || s_vs !== 1'b0 || s_valid !== 1'b0) held_bad++;
        end
        total++; if (held_bad != 0) begin bad++; $display("FAIL reset_held: got %0d active cycles, expected 0", held_bad); end
    endtask

    task automatic test_basic_frame();
        logic [DW-1:0] e;
        int lat_bad;
        do_reset(1'b1);
        run_frame(-1, 1'b0);
        total++; if (timed_out) begin bad++; $display("FAIL basic_timeout: got timeout, expected frame end"); end
        total++; if (lead != VB + 1) begin bad++; $display("FAIL basic_lead: got %0d, expected %0d", lead, VB + 1); end
        total++; if (pulses != W * H) begin bad++; $display("FAIL basic_pulses: got %0d, expected %0d", pulses, W * H); end
        total++; if (vs_cnt != W * H + (H - 1) * HB) begin bad++; $display("FAIL basic_vsync_len: got %0d, expected %0d", vs_cnt, W * H + (H - 1) * HB); end
        total++; if (hs_run.size() != H) begin bad++; $display("FAIL basic_hs_lines: got %0d, expected %0d", hs_run.size(), H); end
        for (int i = 0; i < hs_run.size(); i++) begin
            total++; if (hs_run[i] != W) begin bad++; $display("FAIL basic_hs_len[%0d]: got %0d, expected %0d", i, hs_run[i], W); end
        end
        total++; if (gap_run.size() != H - 1) begin bad++; $display("FAIL basic_hblank_cnt: got %0d, expected %0d", gap_run.size(), H - 1); end
        for (int i = 0; i < gap_run.size(); i++) begin
            total++; if (gap_run[i] != HB) begin bad++; $display("FAIL basic_hblank_len[%0d]: got %0d, expected %0d", i, gap_run[i], HB); end
        end
        total++; if (fd_cnt != 1) begin bad++; $display("FAIL basic_fdone_cnt: got %0d, expected 1", fd_cnt); end
        total++; if (fd_aligned != 1) begin bad++; $display("FAIL basic_fdone_pos: got %0d, expected 1", fd_aligned); end
        total++; if (bad_gray != 0) begin bad++; $display("FAIL basic_gray_idle: got %0d nonzero, expected 0", bad_gray); end
        for (int i = 0; i < got_q.size(); i++) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++; $display("FAIL basic_data[%0d]: got %h, expected nothing", i, got_q[i]);
            end else begin
                e = exp_q.pop_front();
                if (got_q[i] !== e) begin bad++; $display("FAIL basic_data[%0d]: got %h, expected %h", i, got_q[i], e); end
            end
        end
        lat_bad = (out_idx.size() == hs_idx.size()) ? 0 : 1;
        for (int i = 0; i < out_idx.size() && i < hs_idx.size(); i++)
            if (out_idx[i] - hs_idx[i] != 1) lat_bad++;
        total++; if (lat_bad != 0) begin bad++; $display("FAIL basic_latency: got %0d off-by pixels, expected 0", lat_bad); end
    endtask

    task automatic test_stall();
        logic [DW-1:0] e;
        int exp_hs[3];
        int gap;
        exp_hs[0] = W; exp_hs[1] = W + 2; exp_hs[2] = W;
        do_reset(1'b1);
        run_frame(W + 2, 1'b0);
        total++; if (timed_out) begin bad++; $display("FAIL stall_timeout: got timeout, expected frame end"); end
        total++; if (pulses != W * H) begin bad++; $display("FAIL stall_pulses: got %0d, expected %0d", pulses, W * H); end
        total++; if (hs_run.size() != H) begin bad++; $display("FAIL stall_hs_lines: got %0d, expected %0d", hs_run.size(), H); end
        for (int i = 0; i < hs_run.size() && i < H; i++) begin
            total++; if (hs_run[i] != exp_hs[i]) begin bad++; $display("FAIL stall_hs_len[%0d]: got %0d, expected %0d", i, hs_run[i], exp_hs[i]); end
        end
        gap = (out_idx.size() > W + 2) ? out_idx[W + 2] - out_idx[W + 1] - 1 : -1;
        total++; if (gap != 2) begin bad++; $display("FAIL stall_valid_gap: got %0d, expected 2", gap); end
        total++; if (vs_cnt != W * H + 2 + (H - 1) * HB) begin bad++; $display("FAIL stall_vsync_len: got %0d, expected %0d", vs_cnt, W * H + 2 + (H - 1) * HB); end
        for (int i = 0; i < got_q.size(); i++) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++; $display("FAIL stall_data[%0d]: got %h, expected nothing", i, got_q[i]);
            end else begin
                e = exp_q.pop_front();
                if (got_q[i] !== e) begin bad++; $display("FAIL stall_data[%0d]: got %h, expected %h", i, got_q[i], e); end
            end
        end
    endtask

    task automatic test_enable_drop();
        int idle_bad;
        do_reset(1'b1);
        run_frame(-1, 1'b1);
        total++; if (enable !== 1'b0) begin bad++; $display("FAIL drop_not_applied: got %b, expected 0", enable); end
        total++; if (pulses != W * H) begin bad++; $display("FAIL drop_pulses: got %0d, expected %0d", pulses, W * H); end
        total++; if (fd_cnt != 1) begin bad++; $display("FAIL drop_fdone_cnt: got %0d, expected 1", fd_cnt); end
        idle_bad = 0;
        for (int i = 0; i < 20; i++) begin
            tick(1'b1);
            if (s_ready !== 1'b0 || s_vs !== 1'b0 || s_hs !== 1'b0 || s_valid !== 1'b0) idle_bad++;
        end
        total++; if (idle_bad != 0) begin bad++; $display("FAIL drop_idle: got %0d active cycles, expected 0", idle_bad); end
        total++; if (n_push != W * H) begin bad++; $display("FAIL drop_handshakes: got %0d, expected %0d", n_push, W * H); end
    endtask

    task automatic test_midline_reset();
        logic [DW-1:0] e;
        bit reached;
        do_reset(1'b1);
        reached = 1'b0;
        for (int c = 0; c < 100 && !reached; c++) begin
            tick(1'b1);
            if (n_push == W + 1) reached = 1'b1;
        end
        total++; if (!reached) begin bad++; $display("FAIL mid_reach: got %0d handshakes, expected %0d", n_push, W + 1); end
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        total++; if (gray_valid !== 1'b0) begin bad++; $display("FAIL mid_valid: got %b, expected 0", gray_valid); end
        total++; if (gray !== '0) begin bad++; $display("FAIL mid_gray: got %h, expected 00", gray); end
        total++; if (gray_hsync !== 1'b0) begin bad++; $display("FAIL mid_hsync: got %b, expected 0", gray_hsync); end
        total++; if (gray_vsync !== 1'b0) begin bad++; $display("FAIL mid_vsync: got %b, expected 0", gray_vsync); end
        total++; if (src_ready !== 1'b0) begin bad++; $display("FAIL mid_ready: got %b, expected 0", src_ready); end
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        run_frame(-1, 1'b0);
        total++; if (lead != VB + 1) begin bad++; $display("FAIL mid_lead: got %0d, expected %0d", lead, VB + 1); end
        total++; if (pulses != W * H) begin bad++; $display("FAIL mid_pulses: got %0d, expected %0d", pulses, W * H); end
        total++; if (hs_run.size() != H) begin bad++; $display("FAIL mid_hs_lines: got %0d, expected %0d", hs_run.size(), H); end
        for (int i = 0; i < got_q.size(); i++) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++; $display("FAIL mid_data[%0d]: got %h, expected nothing", i, got_q[i]);
            end else begin
                e = exp_q.pop_front();
                if (got_q[i] !== e) begin bad++; $display("FAIL mid_data[%0d]: got %h, expected %h", i, got_q[i], e); end
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [DW-1:0] e;
        int fd1;
        int gap;
        do_reset(1'b1);
        run_frame(-1, 1'b0);
        fd1 = fd_idx;
        total++; if (pulses != W * H) begin bad++; $display("FAIL b2b_pulses1: got %0d, expected %0d", pulses, W * H); end
        for (int i = 0; i < got_q.size(); i++)
            if (exp_q.size() > 0) e = exp_q.pop_front();
        run_frame(-1, 1'b0);
        gap = first_hs_idx - fd1 - 1;
        total++; if (gap != VB) begin bad++; $display("FAIL b2b_gap: got %0d, expected %0d", gap, VB); end
        total++; if (pulses != W * H) begin bad++; $display("FAIL b2b_pulses2: got %0d, expected %0d", pulses, W * H); end
        total++; if (fd_cnt != 1) begin bad++; $display("FAIL b2b_fdone_cnt: got %0d, expected 1", fd_cnt); end
        for (int i = 0; i < got_q.size(); i++) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++; $display("FAIL b2b_data[%0d]: got %h, expected nothing", i, got_q[i]);
            end else begin
                e = exp_q.pop_front();
                if (got_q[i] !== e) begin bad++; $display("FAIL b2b_data[%0d]: got %h, expected %h", i, got_q[i], e); end
            end
        end
        enable = 1'b0;
    endtask

    initial begin
        rst_n     = 1'b0;
        enable    = 1'b0;
        src_valid = 1'b0;
        src_data  = '0;
        test_reset();
        test_basic_frame();
        test_stall();
        test_enable_drop();
        test_midline_reset();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
